// File: rtl/sc_pointgrid_ctrl.sv
// sc_pointgrid_ctrl: player-position controller for the Frogger datapath.
// Converts active-low start/direction buttons into a bounded (row, col)
// position on a ROWS x COLS grid, with move/bump strobes, goal flag and
// optional auto-repeat while a direction button is held.
module sc_pointgrid_ctrl #(
    parameter int ROWS          = 8,
    parameter int COLS          = 8,
    parameter int ROW_W         = 3,
    parameter int COL_W         = 3,
    parameter int START_COL     = 3,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic             SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic             SC_STATEMACHINEPOINT_RESET_InHigh,
    input  logic             startGame_InLow,
    input  logic             up_InLow,
    input  logic             down_InLow,
    input  logic             left_InLow,
    input  logic             right_InLow,
    input  logic             freeze_InHigh,
    output logic [ROW_W-1:0] row_Out,
    output logic [COL_W-1:0] col_Out,
    output logic             active_Out,
    output logic             atGoal_Out,
    output logic             moved_Out,
    output logic             bump_Out
);

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_IDLE  = 3'd1,
        ST_CHECK = 3'd2,
        ST_INIT  = 3'd3,
        ST_MOVE  = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    localparam int CNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX   = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] COL_START = COL_W'(START_COL);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);

    state_t             state_q, state_d;
    dir_t               dir_q,   dir_d;
    logic [ROW_W-1:0]   row_q,   row_d;
    logic [COL_W-1:0]   col_q,   col_d;
    logic               active_q, active_d;
    logic               atgoal_q, atgoal_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic               move_legal;
    logic [ROW_W-1:0]   row_mv;
    logic [COL_W-1:0]   col_mv;
    logic               dir_held;
    logic               all_high;
    logic               moved;
    logic               bump;

    assign all_high = startGame_InLow & up_InLow & down_InLow & left_InLow & right_InLow;

    // Register stage: state, position, flags and repeat counter; async reset.
    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
            state_q  <= ST_RESET;
            dir_q    <= DIR_NONE;
            row_q    <= '0;
            col_q    <= COL_START;
            active_q <= 1'b0;
            atgoal_q <= (ROWS == 1);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            row_q    <= row_d;
            col_q    <= col_d;
            active_q <= active_d;
            atgoal_q <= atgoal_d;
            cnt_q    <= cnt_d;
        end
    end

    // Candidate position for the latched direction and whether it is allowed.
    always_comb begin
        move_legal = 1'b0;
        row_mv     = row_q;
        col_mv     = col_q;
        case (dir_q)
            DIR_UP: if (row_q < ROW_MAX) begin
                move_legal = 1'b1;
                row_mv     = row_q + ROW_W'(1);
            end
            DIR_DOWN: if (row_q > '0) begin
                move_legal = 1'b1;
                row_mv     = row_q - ROW_W'(1);
            end
            DIR_LEFT: if (col_q > '0) begin
                move_legal = 1'b1;
                col_mv     = col_q - COL_W'(1);
            end
            DIR_RIGHT: if (col_q < COL_MAX) begin
                move_legal = 1'b1;
                col_mv     = col_q + COL_W'(1);
            end
            default: move_legal = 1'b0;
        endcase
        // Reaching the goal freezes the player until the next start.
        if (atgoal_q) begin
            move_legal = 1'b0;
        end
    end

    // Whether the button matching the latched direction is still pressed.
    always_comb begin
        case (dir_q)
            DIR_UP:    dir_held = ~up_InLow;
            DIR_DOWN:  dir_held = ~down_InLow;
            DIR_LEFT:  dir_held = ~left_InLow;
            DIR_RIGHT: dir_held = ~right_InLow;
            default:   dir_held = 1'b0;
        endcase
    end

    // Next-state, position update and strobe decode.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        row_d    = row_q;
        col_d    = col_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        moved    = 1'b0;
        bump     = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_IDLE;
            ST_IDLE: begin
                if (!startGame_InLow) begin
                    state_d = ST_INIT;
                end
            end
            ST_CHECK: begin
                if (!startGame_InLow) begin
                    state_d = ST_INIT;
                end else if (!freeze_InHigh) begin
                    if (!up_InLow) begin
                        dir_d   = DIR_UP;
                        state_d = ST_MOVE;
                    end else if (!down_InLow) begin
                        dir_d   = DIR_DOWN;
                        state_d = ST_MOVE;
                    end else if (!left_InLow) begin
                        dir_d   = DIR_LEFT;
                        state_d = ST_MOVE;
                    end else if (!right_InLow) begin
                        dir_d   = DIR_RIGHT;
                        state_d = ST_MOVE;
                    end
                end
            end
            ST_INIT: begin
                row_d    = '0;
                col_d    = COL_START;
                active_d = 1'b1;
                // No direction is latched after a start, so a held button cannot auto-repeat.
                dir_d    = DIR_NONE;
                cnt_d    = '0;
                state_d  = ST_HOLD;
            end
            ST_MOVE: begin
                moved = move_legal;
                bump  = ~move_legal;
                if (move_legal) begin
                    row_d = row_mv;
                    col_d = col_mv;
                end
                cnt_d   = '0;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (all_high) begin
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end else if ((REPEAT_CYCLES > 0) && dir_held) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_MOVE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        atgoal_d = (row_d == ROW_MAX);
    end

    assign row_Out    = row_q;
    assign col_Out    = col_q;
    assign active_Out = active_q;
    assign atGoal_Out = atgoal_q;
    assign moved_Out  = moved;
    assign bump_Out   = bump;

endmodule

// File: tb/tb_sc_pointgrid_ctrl.sv
// Directed testbench for sc_pointgrid_ctrl: a default instance (no repeat)
// and a second instance with REPEAT_CYCLES=4 for auto-repeat.
module tb_sc_pointgrid_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic start = 1'b1, up = 1'b1, down = 1'b1, left = 1'b1, right = 1'b1, freeze = 1'b0;
    logic [2:0] row, col;
    logic active, atgoal, moved, bump;

    logic start_r = 1'b1, up_r = 1'b1, down_r = 1'b1, left_r = 1'b1, right_r = 1'b1, freeze_r = 1'b0;
    logic [2:0] row_r, col_r;
    logic active_r, atgoal_r, moved_r, bump_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sc_pointgrid_ctrl #(
        .ROWS(8), .COLS(8), .ROW_W(3), .COL_W(3), .START_COL(3), .REPEAT_CYCLES(0)
    ) dut (
        .SC_STATEMACHINEPOINT_CLOCK_50    (clk),
        .SC_STATEMACHINEPOINT_RESET_InHigh(rst),
        .startGame_InLow(start),
        .up_InLow       (up),
        .down_InLow     (down),
        .left_InLow     (left),
        .right_InLow    (right),
        .freeze_InHigh  (freeze),
        .row_Out        (row),
        .col_Out        (col),
        .active_Out     (active),
        .atGoal_Out     (atgoal),
        .moved_Out      (moved),
        .bump_Out       (bump)
    );

    sc_pointgrid_ctrl #(
        .ROWS(8), .COLS(8), .ROW_W(3), .COL_W(3), .START_COL(3), .REPEAT_CYCLES(4)
    ) dut_r (
        .SC_STATEMACHINEPOINT_CLOCK_50    (clk),
        .SC_STATEMACHINEPOINT_RESET_InHigh(rst),
        .startGame_InLow(start_r),
        .up_InLow       (up_r),
        .down_InLow     (down_r),
        .left_InLow     (left_r),
        .right_InLow    (right_r),
        .freeze_InHigh  (freeze_r),
        .row_Out        (row_r),
        .col_Out        (col_r),
        .active_Out     (active_r),
        .atGoal_Out     (atgoal_r),
        .moved_Out      (moved_r),
        .bump_Out       (bump_r)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // b: 0 up, 1 down, 2 left, 3 right
    task automatic set_btn(input int b, input logic v);
        case (b)
            0: up = v;
            1: down = v;
            2: left = v;
            default: right = v;
        endcase
    endtask

    // Press a direction from CHECK, capture the MOVE-cycle strobes, release, return to CHECK.
    task automatic press(input int b, output logic mv, output logic bp);
        set_btn(b, 1'b0);
        tick;
        mv = moved;
        bp = bump;
        set_btn(b, 1'b1);
        tick;
        tick;
    endtask

    // Start pulse from CHECK/IDLE; ends back in CHECK.
    task automatic do_start;
        start = 1'b0;
        tick;
        start = 1'b1;
        tick;
        tick;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (row !== 3'd0 || col !== 3'd3 || active !== 1'b0 || atgoal !== 1'b0 || moved !== 1'b0 || bump !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: row=%0d col=%0d act=%b goal=%b mv=%b bp=%b, need 0 3 0 0 0 0",
                     row, col, active, atgoal, moved, bump);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_idle_start;
        int strobes = 0;
        up = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (moved === 1'b1 || bump === 1'b1) strobes++;
        end
        up = 1'b1;
        checks++;
        if (strobes != 0 || row !== 3'd0 || col !== 3'd3 || active !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: strobes=%0d row=%0d col=%0d act=%b, need 0 0 3 0", strobes, row, col, active);
        end
        start = 1'b0;
        tick;
        start = 1'b1;
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL start_init_cycle: act=%b, need 0", active);
        end
        tick;
        checks++;
        if (active !== 1'b1 || row !== 3'd0 || col !== 3'd3) begin
            errors++;
            $display("FAIL start_applied: act=%b row=%0d col=%0d, need 1 0 3", active, row, col);
        end
        tick;
    endtask

    task automatic test_single_move;
        int pulses = 0;
        up = 1'b0;
        tick;
        checks++;
        if (moved !== 1'b1 || row !== 3'd0) begin
            errors++;
            $display("FAIL single_strobe: mv=%b row=%0d, need 1 0", moved, row);
        end
        tick;
        checks++;
        if (moved !== 1'b0 || row !== 3'd1 || atgoal !== 1'b0) begin
            errors++;
            $display("FAIL single_update: mv=%b row=%0d goal=%b, need 0 1 0", moved, row, atgoal);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            if (moved === 1'b1) pulses++;
        end
        up = 1'b1;
        tick;
        tick;
        checks++;
        if (pulses != 0 || row !== 3'd1 || col !== 3'd3) begin
            errors++;
            $display("FAIL single_no_repeat: extra=%0d row=%0d col=%0d, need 0 1 3", pulses, row, col);
        end
    endtask

    task automatic test_edges;
        logic mv, bp;
        press(1, mv, bp);
        checks++;
        if (mv !== 1'b1 || bp !== 1'b0 || row !== 3'd0) begin
            errors++;
            $display("FAIL down_legal: mv=%b bp=%b row=%0d, need 1 0 0", mv, bp, row);
        end
        press(1, mv, bp);
        checks++;
        if (mv !== 1'b0 || bp !== 1'b1 || row !== 3'd0) begin
            errors++;
            $display("FAIL down_bump: mv=%b bp=%b row=%0d, need 0 1 0", mv, bp, row);
        end
        for (int i = 0; i < 4; i++) press(3, mv, bp);
        checks++;
        if (col !== 3'd7) begin
            errors++;
            $display("FAIL right_walk: col=%0d, need 7", col);
        end
        press(3, mv, bp);
        checks++;
        if (mv !== 1'b0 || bp !== 1'b1 || col !== 3'd7) begin
            errors++;
            $display("FAIL right_bump: mv=%b bp=%b col=%0d, need 0 1 7", mv, bp, col);
        end
        for (int i = 0; i < 7; i++) press(2, mv, bp);
        checks++;
        if (col !== 3'd0) begin
            errors++;
            $display("FAIL left_walk: col=%0d, need 0", col);
        end
        press(2, mv, bp);
        checks++;
        if (mv !== 1'b0 || bp !== 1'b1 || col !== 3'd0) begin
            errors++;
            $display("FAIL left_bump: mv=%b bp=%b col=%0d, need 0 1 0", mv, bp, col);
        end
    endtask

    task automatic test_priority;
        up = 1'b0;
        left = 1'b0;
        tick;
        checks++;
        if (moved !== 1'b1) begin
            errors++;
            $display("FAIL prio_strobe: mv=%b, need 1", moved);
        end
        up = 1'b1;
        left = 1'b1;
        tick;
        tick;
        checks++;
        if (row !== 3'd1 || col !== 3'd0) begin
            errors++;
            $display("FAIL prio_up_over_left: row=%0d col=%0d, need 1 0", row, col);
        end
        start = 1'b0;
        up = 1'b0;
        tick;
        checks++;
        if (moved !== 1'b0 || bump !== 1'b0) begin
            errors++;
            $display("FAIL prio_start_no_move: mv=%b bp=%b, need 0 0", moved, bump);
        end
        start = 1'b1;
        up = 1'b1;
        tick;
        checks++;
        if (row !== 3'd0 || col !== 3'd3 || active !== 1'b1) begin
            errors++;
            $display("FAIL prio_start_init: row=%0d col=%0d act=%b, need 0 3 1", row, col, active);
        end
        tick;
    endtask

    task automatic test_goal;
        logic mv, bp;
        for (int i = 0; i < 6; i++) press(0, mv, bp);
        checks++;
        if (row !== 3'd6 || atgoal !== 1'b0) begin
            errors++;
            $display("FAIL goal_climb: row=%0d goal=%b, need 6 0", row, atgoal);
        end
        up = 1'b0;
        tick;
        checks++;
        if (moved !== 1'b1 || atgoal !== 1'b0) begin
            errors++;
            $display("FAIL goal_last_move: mv=%b goal=%b, need 1 0", moved, atgoal);
        end
        up = 1'b1;
        tick;
        checks++;
        if (row !== 3'd7 || atgoal !== 1'b1) begin
            errors++;
            $display("FAIL goal_reached: row=%0d goal=%b, need 7 1", row, atgoal);
        end
        tick;
        press(0, mv, bp);
        checks++;
        if (mv !== 1'b0 || bp !== 1'b1 || row !== 3'd7) begin
            errors++;
            $display("FAIL goal_up_bump: mv=%b bp=%b row=%0d, need 0 1 7", mv, bp, row);
        end
        press(1, mv, bp);
        checks++;
        if (mv !== 1'b0 || bp !== 1'b1 || row !== 3'd7) begin
            errors++;
            $display("FAIL goal_down_bump: mv=%b bp=%b row=%0d, need 0 1 7", mv, bp, row);
        end
        do_start;
        checks++;
        if (row !== 3'd0 || atgoal !== 1'b0) begin
            errors++;
            $display("FAIL goal_cleared: row=%0d goal=%b, need 0 0", row, atgoal);
        end
    endtask

    task automatic test_freeze;
        logic mv, bp;
        int strobes = 0;
        freeze = 1'b1;
        up = 1'b0;
        right = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (moved === 1'b1 || bump === 1'b1) strobes++;
        end
        up = 1'b1;
        right = 1'b1;
        tick;
        checks++;
        if (strobes != 0 || row !== 3'd0 || col !== 3'd3) begin
            errors++;
            $display("FAIL freeze_block: strobes=%0d row=%0d col=%0d, need 0 0 3", strobes, row, col);
        end
        freeze = 1'b0;
        press(0, mv, bp);
        freeze = 1'b1;
        start = 1'b0;
        tick;
        start = 1'b1;
        tick;
        checks++;
        if (row !== 3'd0 || col !== 3'd3) begin
            errors++;
            $display("FAIL freeze_start: row=%0d col=%0d, need 0 3", row, col);
        end
        tick;
        freeze = 1'b0;
    endtask

    task automatic test_repeat;
        logic emv, ebp;
        start_r = 1'b0;
        tick;
        start_r = 1'b1;
        tick;
        tick;
        checks++;
        if (col_r !== 3'd3 || active_r !== 1'b1) begin
            errors++;
            $display("FAIL rep_start: col=%0d act=%b, need 3 1", col_r, active_r);
        end
        right_r = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            tick;
            emv = (i == 1 || i == 6 || i == 11 || i == 16);
            ebp = (i == 21);
            checks++;
            if (moved_r !== emv || bump_r !== ebp) begin
                errors++;
                $display("FAIL rep_offset_%0d: mv=%b bp=%b, need %b %b", i, moved_r, bump_r, emv, ebp);
            end
        end
        right_r = 1'b1;
        tick;
        tick;
        checks++;
        if (col_r !== 3'd7) begin
            errors++;
            $display("FAIL rep_clamp: col=%0d, need 7", col_r);
        end
    endtask

    task automatic test_reset_mid_hold;
        up = 1'b0;
        tick;
        tick;
        checks++;
        if (row !== 3'd1 || active !== 1'b1) begin
            errors++;
            $display("FAIL hold_setup: row=%0d act=%b, need 1 1", row, active);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (row !== 3'd0 || col !== 3'd3 || active !== 1'b0 || atgoal !== 1'b0 || moved !== 1'b0 || bump !== 1'b0
            || col_r !== 3'd3 || active_r !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: row=%0d col=%0d act=%b goal=%b mv=%b bp=%b col_r=%0d act_r=%b, need 0 3 0 0 0 0 3 0",
                     row, col, active, atgoal, moved, bump, col_r, active_r);
        end
        up = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        tick;
        checks++;
        if (active !== 1'b0 || moved !== 1'b0 || row !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_idle: act=%b mv=%b row=%0d, need 0 0 0", active, moved, row);
        end
    endtask

    initial begin
        test_reset;
        test_idle_start;
        test_single_move;
        test_edges;
        test_priority;
        test_goal;
        test_freeze;
        test_repeat;
        test_reset_mid_hold;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
